// File: rtl/rv32i_dii_sequencer.sv
// Direct-instruction-injection sequencer: buffers host commands, issues one instruction at a
// time to the core and emits one trace token per retirement. Optional watchdog: DII_WATCHDOG_EN.
module rv32i_dii_sequencer #(
  parameter int DEPTH      = 4,
  parameter int RST_CYCLES = 4
`ifdef DII_WATCHDOG_EN
  ,
  parameter int TIMEOUT    = 256
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_reset,
  input  logic [31:0] cmd_instr,
  output logic        core_rst_req,
  output logic        core_halt,
  output logic [31:0] core_instr,
  output logic        core_instr_valid,
  input  logic        core_retire,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [1:0]  trace_kind,
  output logic [15:0] trace_seq
);
  // Handshakes: a command transfers when cmd_valid && cmd_ready, a token when
  // trace_valid && trace_ready; kind/seq stay stable while trace_valid waits for ready.
  typedef enum logic [2:0] {S_RESET, S_RUN, S_WAIT_RETIRE, S_TRACE, S_DRAIN} state_t;

  localparam logic [1:0] K_RETIRE  = 2'd0;
  localparam logic [1:0] K_EOT     = 2'd1;
  localparam logic [1:0] K_TIMEOUT = 2'd2;
  localparam int AW  = $clog2(DEPTH);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [32:0]      r_mem [DEPTH];
  logic [RCW-1:0]   r_rst_cnt;
  logic [31:0]      r_core_instr;
  logic             r_issue;
  logic             r_eot_pending;
  logic [1:0]       r_kind;
  logic [15:0]      r_seq;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [32:0]      w_head;
  logic             w_rst_done;
  logic             w_retire;
  logic             w_accept;
  logic             w_timeout;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = cmd_valid && !w_full;
  assign w_pop      = (r_state == S_RUN) && !w_empty;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rst_done = (r_rst_cnt == RCW'(RST_CYCLES - 1));
  // The issue cycle itself never counts as a retirement.
  assign w_retire   = (r_state == S_WAIT_RETIRE) && core_retire && !r_issue;
  assign w_accept   = (r_state == S_TRACE) && trace_ready;

`ifdef DII_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd;

  assign w_timeout = (r_state == S_WAIT_RETIRE) && !w_retire && (r_wd == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || r_issue) r_wd <= '0;
    else if (r_state == S_WAIT_RETIRE) r_wd <= r_wd + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Command FIFO; a timeout discards everything still queued.
  always_ff @(posedge clk) begin
    if (rst || w_timeout) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_is_reset, cmd_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:       if (w_rst_done) w_next = r_eot_pending ? S_TRACE : S_RUN;
      S_RUN:         if (!w_empty) w_next = w_head[32] ? S_DRAIN : S_WAIT_RETIRE;
      S_WAIT_RETIRE: if (w_retire || w_timeout) w_next = S_TRACE;
      S_TRACE:       if (w_accept) w_next = (r_kind == K_TIMEOUT) ? S_RESET : S_RUN;
      S_DRAIN:       w_next = S_RESET;
      default:       w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt     <= '0;
      r_core_instr  <= 32'h0000_0013;
      r_issue       <= 1'b0;
      r_eot_pending <= 1'b0;
      r_kind        <= K_RETIRE;
      r_seq         <= 16'd0;
    end else begin
      r_issue   <= 1'b0;
      r_rst_cnt <= (r_state == S_RESET && !w_rst_done) ? r_rst_cnt + 1'b1 : '0;
      if (w_pop && !w_head[32]) begin
        r_core_instr <= w_head[31:0];
        r_issue      <= 1'b1;
      end
      if (w_pop && w_head[32]) r_eot_pending <= 1'b1;
      if (r_state == S_RESET && w_rst_done && r_eot_pending) r_kind <= K_EOT;
      if (w_retire)  r_kind <= K_RETIRE;
      if (w_timeout) r_kind <= K_TIMEOUT;
      if (w_accept) begin
        case (r_kind)
          K_RETIRE: r_seq <= r_seq + 16'd1;
          K_EOT: begin
            r_seq         <= 16'd0;
            r_eot_pending <= 1'b0;
          end
          default: r_eot_pending <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    cmd_ready        = !rst && !w_full;
    core_rst_req     = (r_state == S_RESET);
    core_halt        = (r_state != S_WAIT_RETIRE);
    core_instr       = r_core_instr;
    core_instr_valid = r_issue;
    trace_valid      = (r_state == S_TRACE);
    trace_kind       = (r_state == S_TRACE) ? r_kind : K_RETIRE;
    trace_seq        = (r_state == S_TRACE) ? r_seq : 16'd0;
  end
endmodule

// File: tb/tb_rv32i_dii_sequencer.sv
// Directed bench for rv32i_dii_sequencer; the watchdog section needs DII_WATCHDOG_EN.
module tb_rv32i_dii_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_reset;
  logic [31:0] cmd_instr;
  logic        core_rst_req;
  logic        core_halt;
  logic [31:0] core_instr;
  logic        core_instr_valid;
  logic        core_retire = 1'b0;
  logic        trace_valid;
  logic        trace_ready;
  logic [1:0]  trace_kind;
  logic [15:0] trace_seq;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int iss_cyc = 0;
  int n_rq   = 0;
  int ret_delay = 0;
  int ret_cnt = 0;
  int req_n  = 0;
  int ack_n  = 0;
  logic [31:0] iss_q[$];
  logic [17:0] tok_q[$];

  rv32i_dii_sequencer #(
    .DEPTH(4),
    .RST_CYCLES(4)
`ifdef DII_WATCHDOG_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_reset(cmd_is_reset), .cmd_instr(cmd_instr),
    .core_rst_req(core_rst_req), .core_halt(core_halt),
    .core_instr(core_instr), .core_instr_valid(core_instr_valid),
    .core_retire(core_retire),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_seq(trace_seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and core model: records issues/accepted tokens, counts reset-request
  // cycles and drives core_retire either after ret_delay cycles or on request.
  always @(negedge clk) begin
    core_retire = 1'b0;
    if (!rst) begin
      if (core_instr_valid) begin
        iss_q.push_back(core_instr);
        iss_cyc = cyc;
      end
      if (trace_valid && trace_ready) tok_q.push_back({trace_kind, trace_seq});
      if (core_rst_req) n_rq++;
      if (ret_cnt > 0) begin
        ret_cnt--;
        if (ret_cnt == 0) core_retire = 1'b1;
      end
      if (core_instr_valid && ret_delay > 0) ret_cnt = ret_delay;
      if (req_n != ack_n) begin
        core_retire = 1'b1;
        ack_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic is_rst);
    cmd_valid    = 1'b1;
    cmd_instr    = instr;
    cmd_is_reset = is_rst;
    tick();
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_tokens(input int n, input string tag);
    for (int i = 0; i < 400 && tok_q.size() < n; i++) tick();
    chk(tag, tok_q.size(), n);
  endtask

  int base_i, base_t, rq_base, cnt, bad;
  logic [31:0] f_instr [6];

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_is_reset = 1'b0; cmd_instr = '0;
    trace_ready = 1'b1;
    tick(); tick();
    chk("rst_core_rst_req", core_rst_req, 1);
    chk("rst_core_halt", core_halt, 1);
    chk("rst_core_instr", core_instr, 32'h13);
    chk("rst_instr_valid", core_instr_valid, 0);
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_trace_kind", trace_kind, 0);
    chk("rst_trace_seq", trace_seq, 0);
    chk("rst_cmd_ready", cmd_ready, 0);

    // Power-on reset sequence with no commands.
    rst = 1'b0;
    #1;
    chk("t1_cmd_ready", cmd_ready, 1);
    cnt = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_rst_req) cnt++;
      if (trace_valid || !core_halt) bad++;
      tick();
    end
    chk("t1_rst_req_cycles", cnt, 4);
    chk("t1_no_trace_halted", bad, 0);

    // Three instructions, retire 2 cycles after issue.
    ret_delay = 2;
    base_i = iss_q.size(); base_t = tok_q.size();
    push(32'h0010_0093, 0); push(32'h0020_0113, 0); push(32'h0030_8193, 0);
    wait_tokens(base_t + 3, "t2_token_count");
    chk("t2_issue0", iss_q[base_i], 32'h0010_0093);
    chk("t2_issue1", iss_q[base_i + 1], 32'h0020_0113);
    chk("t2_issue2", iss_q[base_i + 2], 32'h0030_8193);
    chk("t2_tok0", {14'd0, tok_q[base_t]},     {14'd0, 2'd0, 16'd0});
    chk("t2_tok1", {14'd0, tok_q[base_t + 1]}, {14'd0, 2'd0, 16'd1});
    chk("t2_tok2", {14'd0, tok_q[base_t + 2]}, {14'd0, 2'd0, 16'd2});

    // Back-pressure on the trace port holds the token and blocks the next issue.
    trace_ready = 1'b0;
    base_i = iss_q.size(); base_t = tok_q.size();
    push(32'h0040_0213, 0); push(32'h0050_0293, 0);
    for (int i = 0; i < 50 && !trace_valid; i++) tick();
    chk("t3_trace_valid", trace_valid, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!trace_valid || trace_kind != 2'd0 || trace_seq != 16'd3 || !core_halt ||
          core_instr_valid) bad++;
      tick();
    end
    chk("t3_token_held", bad, 0);
    chk("t3_no_second_issue", iss_q.size() - base_i, 1);
    trace_ready = 1'b1;
    wait_tokens(base_t + 2, "t3_token_count");
    chk("t3_issue1", iss_q[base_i + 1], 32'h0050_0293);
    chk("t3_tok0", {14'd0, tok_q[base_t]},     {14'd0, 2'd0, 16'd3});
    chk("t3_tok1", {14'd0, tok_q[base_t + 1]}, {14'd0, 2'd0, 16'd4});

    // FIFO fill: one in flight plus four buffered, the sixth waits for a slot.
    ret_delay = 0;
    base_i = iss_q.size(); base_t = tok_q.size();
    for (int i = 0; i < 6; i++) f_instr[i] = 32'h0000_0013 + 32'((i + 1) << 20);
    for (int i = 0; i < 5; i++) push(f_instr[i], 0);
    chk("t4_full_ready", cmd_ready, 0);
    chk("t4_one_issued", iss_q.size() - base_i, 1);
    cmd_valid = 1'b1; cmd_instr = f_instr[5]; cmd_is_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready) bad++;
      tick();
    end
    chk("t4_ready_low_while_full", bad, 0);
    req_n++;
    ret_delay = 2;
    for (int i = 0; i < 30 && !cmd_ready; i++) tick();
    chk("t4_ready_after_free", cmd_ready, 1);
    chk("t4_token_before_slot", tok_q.size() - base_t, 1);
    tick();
    cmd_valid = 1'b0;
    wait_tokens(base_t + 6, "t4_token_count");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_issue%0d", i), iss_q[base_i + i], f_instr[i]);
      chk($sformatf("t4_tok%0d", i), {14'd0, tok_q[base_t + i]}, {14'd0, 2'd0, 16'(5 + i)});
    end

    // End-of-trace: reset command between instructions.
    base_i = iss_q.size(); base_t = tok_q.size(); rq_base = n_rq;
    push(32'h0060_0313, 0); push(32'h0070_0393, 0); push(32'hDEAD_BEEF, 1); push(32'h0080_0413, 0);
    wait_tokens(base_t + 4, "t5_token_count");
    chk("t5_tok0", {14'd0, tok_q[base_t]},     {14'd0, 2'd0, 16'd11});
    chk("t5_tok1", {14'd0, tok_q[base_t + 1]}, {14'd0, 2'd0, 16'd12});
    chk("t5_eot",  {14'd0, tok_q[base_t + 2]}, {14'd0, 2'd1, 16'd13});
    chk("t5_tok_after_eot", {14'd0, tok_q[base_t + 3]}, {14'd0, 2'd0, 16'd0});
    chk("t5_rst_req_cycles", n_rq - rq_base, 4);
    chk("t5_issue_count", iss_q.size() - base_i, 3);
    chk("t5_issue2", iss_q[base_i + 2], 32'h0080_0413);

`ifdef DII_WATCHDOG_EN
    // Watchdog: no retire, two more queued behind the stalled instruction.
    ret_delay = 0;
    base_i = iss_q.size(); base_t = tok_q.size();
    push(32'h0090_0493, 0); push(32'h00A0_0513, 0); push(32'h00B0_0593, 0);
    for (int i = 0; i < 100 && !trace_valid; i++) tick();
    chk("t6_trace_valid", trace_valid, 1);
    chk("t6_timeout_latency", cyc - iss_cyc, 16);
    chk("t6_kind", trace_kind, 2);
    chk("t6_seq", trace_seq, 1);
    rq_base = n_rq;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_rst_req_cycles", n_rq - rq_base, 4);
    chk("t6_token_count", tok_q.size() - base_t, 1);
    chk("t6_fifo_flushed", iss_q.size() - base_i, 1);
    chk("t6_cmd_ready", cmd_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv32i_dii_sequencer.md
Name: rv32i_dii_sequencer

Overview:
Sequences direct-instruction-injection (DII) traffic into rv32i_core. It buffers host commands (instructions, end-of-trace resets) in a FIFO and issues one instruction at a time to the core. It waits for retirement and emits one trace token per retired instruction to the host-side trace packer. It also drives the core reset and halt, so trace packets always line up 1:1 with injected instructions.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
RST_CYCLES, 4, cycles core_rst_req is held per reset sequence (>=1)
TIMEOUT, 256, watchdog limit in cycles from issue to retire (only with DII_WATCHDOG_EN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept (= ~full, no bypass)
cmd_is_reset  in  1  1 = end-of-trace/reset command, 0 = instruction
cmd_instr  in  32  instruction word (ignored when cmd_is_reset)
core_rst_req  out  1  core reset request (active-high)
core_halt  out  1  core must not execute
core_instr  out  32  instruction forced into core
core_instr_valid  out  1  one-cycle issue pulse
core_retire  in  1  core retired the issued instruction (1-cycle pulse)
trace_valid  out  1  trace token valid
trace_ready  in  1  trace consumer accepts
trace_kind  out  2  0 RETIRE, 1 EOT, 2 TIMEOUT
trace_seq  out  16  retire sequence number of token

Behaviour:
- Reset values: cmd_ready=0, core_rst_req=1, core_halt=1, core_instr=0x00000013, core_instr_valid=0, trace_valid=0, trace_kind=0, trace_seq=0. FIFO empty, seq counter 0, state RESET, eot_pending=0.
- rst asserted at any time flushes FIFO and pending trace, aborts in-flight instruction, reloads reset values.
- States: RESET, RUN, WAIT_RETIRE, TRACE, DRAIN.
- RESET: core_rst_req=1, core_halt=1 for exactly RST_CYCLES cycles (counter from 0). Then:
  - eot_pending=1: go TRACE with kind EOT, seq = current counter; on acceptance, counter cleared to 0.
  - eot_pending=0: go RUN.
  - Power-on reset never emits EOT.
- RUN: core_halt=1 while FIFO empty.
  - Head is an instruction: pop it, drive core_instr=head, core_instr_valid=1 for one cycle, core_halt=0, go WAIT_RETIRE.
  - Head is a reset command: pop it, set eot_pending=1, go DRAIN.
- WAIT_RETIRE: core_halt=0. On core_retire go TRACE with kind RETIRE, seq = counter; counter increments (16-bit wrap 0xFFFF->0x0000) on acceptance.
- TRACE: trace_valid=1, kind/seq stable until trace_valid&&trace_ready, core_halt=1. After acceptance:
  - kind RETIRE: go RUN.
  - kind TIMEOUT: set eot_pending=0, go RESET.
  - kind EOT: clear eot_pending, go RUN.
- DRAIN: one cycle (no trace can be pending here by construction), then RESET.
- core_retire outside WAIT_RETIRE is ignored. Issue and retire in the same cycle is not possible; retire is sampled from the cycle after issue.
- cmd_ready = ~full in all states except during rst. A push while full is dropped (host protocol violation).
- core_instr holds its last issued value between issues. Reset commands do not change it.
- Ordering: commands are executed strictly in FIFO order. Instructions pushed after a reset command run after its EOT.
- Minimum issue-to-issue latency: 1 issue + retire latency + 1 trace cycle.

Optional Feature:
DII_WATCHDOG_EN: counter clears on issue and increments in WAIT_RETIRE. On reaching TIMEOUT-1 without core_retire: emit TIMEOUT token with seq = current counter (counter not incremented), flush FIFO, then run the RESET sequence with no EOT. Without the macro: no counter, WAIT_RETIRE waits indefinitely, kind 2 is never produced.

Test Plan:
1. rst high 2 cycles then low, RST_CYCLES=4, no commands -> core_rst_req high exactly 4 cycles after rst release; no trace_valid; core_halt stays 1; cmd_ready=1.
2. Push 0x00100093, 0x00200113, 0x00308193; core_retire 2 cycles after each issue; trace_ready=1 -> core_instr in that order; three RETIRE tokens with seq 0, 1, 2.
3. As in 2, but trace_ready=0 for 10 cycles after the first retire -> token 0 held stable; second instruction not issued until acceptance; core_halt=1 meanwhile.
4. DEPTH=4, push 6 instructions with core_retire held 0 -> first issued, next 4 buffered, cmd_ready=0 until retire plus trace acceptance frees a slot.
5. Push 2 instructions, a reset command, then 1 instruction -> tokens seq 0, 1; core_rst_req high 4 cycles; EOT token seq=2; third instruction's token has seq 0.
6. DII_WATCHDOG_EN, TIMEOUT=16, issue with no retire and 2 more queued -> TIMEOUT token seq=0 16 cycles after issue; FIFO empty; core_rst_req 4 cycles; no EOT.
